// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data RAM port of dmem_arbiter.
// The arbiter takes the slave view; a requester/RAM environment takes the master view.
interface dmem_arbiter_if #(
    parameter int AW = 32
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [31:0]   wdata0;
    logic          ack0;
    logic          err0;
    logic [31:0]   rdata0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [31:0]   wdata1;
    logic          ack1;
    logic          err1;
    logic [31:0]   rdata1;

    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [31:0]   mem_wd;
    logic [31:0]   mem_rd;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rd,
        output ack0, err0, rdata0,
        output ack1, err1, rdata1,
        output mem_we, mem_a, mem_wd
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rd,
        input  ack0, err0, rdata0,
        input  ack1, err1, rdata1,
        input  mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port word RAM.
// Each access runs IDLE/ACK -> SERVE (one RAM cycle) -> ACK (completion pulse).
module dmem_arbiter #(
    parameter int AW          = 32,
    parameter int DEPTH_WORDS = 64
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus,
    output logic [1:0]    o_state
);
    // Handshake: a requester raises req_n with we/addr/wdata stable and holds it
    // until ack_n pulses for one cycle (err_n qualifies that pulse). A req_n still
    // high in the cycle after its ack is treated as a fresh request.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    localparam logic [AW-3:0] W_DEPTH = (AW-2)'(DEPTH_WORDS);

    state_t        r_state;
    state_t        w_next_state;
    logic          r_g;
    logic          r_last;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_err0;
    logic          r_err1;
    logic [31:0]   r_rdata0;
    logic [31:0]   r_rdata1;

    logic          w_elig0;
    logic          w_elig1;
    logic          w_pick;
    logic          w_grant;
    logic          w_serve;
    logic          w_valid;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [31:0]   w_sel_wd;

    // The port being acked still holds req during its ack cycle, so it is masked out.
    always_comb begin
        w_elig0 = bus.req0 && !(r_state == ST_ACK && r_g == 1'b0);
        w_elig1 = bus.req1 && !(r_state == ST_ACK && r_g == 1'b1);
        w_pick  = (w_elig0 && w_elig1) ? !r_last : w_elig1;
    end

    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        case (r_state)
            ST_IDLE, ST_ACK: begin
                if (w_elig0 || w_elig1) begin
                    w_next_state = ST_SERVE;
                    w_grant      = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SERVE: w_next_state = ST_ACK;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_serve    = (r_state == ST_SERVE);
        w_sel_addr = r_g ? bus.addr1  : bus.addr0;
        w_sel_we   = r_g ? bus.we1    : bus.we0;
        w_sel_wd   = r_g ? bus.wdata1 : bus.wdata0;
        w_valid    = (w_sel_addr[1:0] == 2'b00) && (w_sel_addr[AW-1:2] < W_DEPTH);
    end

    // Outside SERVE the RAM address/data are don't-care and simply follow port 0.
    assign bus.mem_we = w_serve && w_sel_we && w_valid;
    assign bus.mem_a  = w_serve ? w_sel_addr : bus.addr0;
    assign bus.mem_wd = w_serve ? w_sel_wd   : bus.wdata0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_g      <= 1'b0;
            r_last   <= 1'b1;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
            r_rdata0 <= 32'd0;
            r_rdata1 <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_grant) begin
                r_g    <= w_pick;
                r_last <= w_pick;
            end
            r_ack0 <= w_serve && !r_g;
            r_ack1 <= w_serve && r_g;
            r_err0 <= w_serve && !r_g && !w_valid;
            r_err1 <= w_serve && r_g && !w_valid;
            if (w_serve && !w_sel_we && w_valid) begin
                if (r_g) begin
                    r_rdata1 <= bus.mem_rd;
                end else begin
                    r_rdata0 <= bus.mem_rd;
                end
            end
        end
    end

    assign bus.ack0   = r_ack0;
    assign bus.ack1   = r_ack1;
    assign bus.err0   = r_err0;
    assign bus.err1   = r_err1;
    assign bus.rdata0 = r_rdata0;
    assign bus.rdata1 = r_rdata1;
    assign o_state    = r_state;
endmodule
